// File: rtl/gppcu_thread_wrbk_if.sv
// Writeback port bundle: ALU result, load-return handshake and register-bank write port.
interface gppcu_thread_wrbk_if #(
    parameter int DW        = 32,
    parameter int AW        = 5,
    parameter int LDQ_DEPTH = 2
);
    localparam int CW = $clog2(LDQ_DEPTH) + 1;

    logic          alu_wr;
    logic [AW-1:0] alu_sel;
    logic [DW-1:0] alu_d;
    logic          alu_stall;
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_sel;
    logic [DW-1:0] ld_d;
    logic [AW-1:0] reg_sel;
    logic [DW-1:0] reg_d;
    logic          wr;
    logic [CW-1:0] ld_pend;

    modport master (
        output alu_wr, alu_sel, alu_d, ld_valid, ld_sel, ld_d,
        input  alu_stall, ld_ready, reg_sel, reg_d, wr, ld_pend
    );

    modport slave (
        input  alu_wr, alu_sel, alu_d, ld_valid, ld_sel, ld_d,
        output alu_stall, ld_ready, reg_sel, reg_d, wr, ld_pend
    );
endinterface

// File: rtl/gppcu_thread_wrbk.sv
// Per-thread writeback arbiter: ALU has priority, queued load returns drain via a starvation counter.
module gppcu_thread_wrbk #(
    parameter int DW         = 32,
    parameter int AW         = 5,
    parameter int LDQ_DEPTH  = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    gppcu_thread_wrbk_if.slave bus
);
    localparam int PW = (LDQ_DEPTH > 1) ? $clog2(LDQ_DEPTH) : 1;
    localparam int CW = $clog2(LDQ_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [AW-1:0] q_sel [LDQ_DEPTH];
    logic [DW-1:0] q_d   [LDQ_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_next;
    logic [SW-1:0] cnt, cnt_next;
    logic          stall, ld_ready, wr;
    logic [AW-1:0] reg_sel;
    logic [DW-1:0] reg_d;
    logic          alu_win, pop, push, q_nempty;

    assign q_nempty = (count != '0);
    assign alu_win  = bus.alu_wr && !stall;
    assign pop      = !alu_win && q_nempty;
    // ld_ready is registered, so a full queue refuses a push even when popping.
    assign push     = bus.ld_valid && ld_ready;

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + CW'(1);
        else if (!push && pop)
            count_next = count - CW'(1);
    end

    always_comb begin
        cnt_next = '0;
        if (alu_win && q_nempty)
            cnt_next = cnt + SW'(1);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_sel[wr_ptr] <= bus.ld_sel;
            q_d[wr_ptr]   <= bus.ld_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            cnt      <= '0;
            stall    <= 1'b0;
            ld_ready <= 1'b0;
            wr       <= 1'b0;
            reg_sel  <= '0;
            reg_d    <= '0;
        end else begin
            count    <= count_next;
            cnt      <= cnt_next;
            stall    <= (cnt_next == SW'(STARVE_MAX));
            ld_ready <= (count_next < CW'(LDQ_DEPTH));
            wr       <= alu_win || pop;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (alu_win) begin
                reg_sel <= bus.alu_sel;
                reg_d   <= bus.alu_d;
            end else if (pop) begin
                reg_sel <= q_sel[rd_ptr];
                reg_d   <= q_d[rd_ptr];
                rd_ptr  <= rd_ptr + PW'(1);
            end
        end
    end

    assign bus.alu_stall = stall;
    assign bus.ld_ready  = ld_ready;
    assign bus.wr        = wr;
    assign bus.reg_sel   = reg_sel;
    assign bus.reg_d     = reg_d;
    assign bus.ld_pend   = count;
endmodule

// File: tb/tb_gppcu_thread_wrbk.sv
// Directed self-checking bench for gppcu_thread_wrbk; inputs driven and outputs sampled on negedge.
module tb_gppcu_thread_wrbk;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    gppcu_thread_wrbk_if #(.DW(32), .AW(5), .LDQ_DEPTH(2)) bus ();

    gppcu_thread_wrbk #(.DW(32), .AW(5), .LDQ_DEPTH(2), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic idle_inputs();
        bus.alu_wr   = 1'b0;
        bus.ld_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.alu_wr   = 1'b1;
        bus.alu_sel  = 5'd31;
        bus.alu_d    = 32'hCAFE0031;
        bus.ld_valid = 1'b1;
        bus.ld_sel   = 5'd2;
        bus.ld_d     = 32'h0000BAD0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.wr !== 1'b0) begin n_fail++; $display("FAIL reset_wr got %0b want 0", bus.wr); end
        n_checks++;
        if (bus.ld_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ld_ready got %0b want 0", bus.ld_ready); end
        n_checks++;
        if (bus.ld_pend !== 2'd0 || bus.alu_stall !== 1'b0 || bus.reg_sel !== 5'd0 || bus.reg_d !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outs got pend=%0d stall=%0b sel=%0d d=%h want 0", bus.ld_pend, bus.alu_stall, bus.reg_sel, bus.reg_d);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.ld_ready !== 1'b1) begin n_fail++; $display("FAIL release_ld_ready got %0b want 1", bus.ld_ready); end
        n_checks++;
        if (bus.ld_pend !== 2'd0) begin n_fail++; $display("FAIL release_no_accept got pend=%0d want 0", bus.ld_pend); end
        n_checks++;
        if (bus.wr !== 1'b1 || bus.reg_sel !== 5'd31) begin
            n_fail++;
            $display("FAIL release_alu got wr=%0b sel=%0d want wr=1 sel=31", bus.wr, bus.reg_sel);
        end
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (bus.ld_pend !== 2'd0 || bus.wr !== 1'b0) begin
            n_fail++;
            $display("FAIL release_idle got pend=%0d wr=%0b want 0 0", bus.ld_pend, bus.wr);
        end
    endtask

    task automatic test_alu_only();
        bus.alu_wr  = 1'b1;
        bus.alu_sel = 5'd7;
        bus.alu_d   = 32'hDEADBEEF;
        @(negedge clk);
        n_checks++;
        if (bus.wr !== 1'b1 || bus.reg_sel !== 5'd7 || bus.reg_d !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL alu_write got wr=%0b sel=%0d d=%h want 1 7 deadbeef", bus.wr, bus.reg_sel, bus.reg_d);
        end
        bus.alu_wr = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.wr !== 1'b0 || bus.reg_sel !== 5'd7 || bus.reg_d !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL alu_hold got wr=%0b sel=%0d d=%h want 0 7 deadbeef", bus.wr, bus.reg_sel, bus.reg_d);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  sel_v [3];
        logic [31:0] d_v   [3];
        sel_v[0] = 5'd5;  d_v[0] = 32'h55550005;
        sel_v[1] = 5'd6;  d_v[1] = 32'h66660006;
        sel_v[2] = 5'd0;  d_v[2] = 32'h00000000;
        for (int i = 0; i < 3; i++) begin
            bus.alu_wr  = 1'b1;
            bus.alu_sel = sel_v[i];
            bus.alu_d   = d_v[i];
            @(negedge clk);
            n_checks++;
            if (bus.wr !== 1'b1 || bus.reg_sel !== sel_v[i] || bus.reg_d !== d_v[i]) begin
                n_fail++;
                $display("FAIL b2b_alu[%0d] got wr=%0b sel=%0d d=%h want 1 %0d %h", i, bus.wr, bus.reg_sel, bus.reg_d, sel_v[i], d_v[i]);
            end
        end
        bus.alu_wr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load_only();
        bus.ld_valid = 1'b1;
        bus.ld_sel   = 5'd3;
        bus.ld_d     = 32'h12345678;
        @(negedge clk);
        n_checks++;
        if (bus.ld_pend !== 2'd1 || bus.wr !== 1'b0) begin
            n_fail++;
            $display("FAIL load_queued got pend=%0d wr=%0b want 1 0", bus.ld_pend, bus.wr);
        end
        bus.ld_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.wr !== 1'b1 || bus.reg_sel !== 5'd3 || bus.reg_d !== 32'h12345678) begin
            n_fail++;
            $display("FAIL load_write got wr=%0b sel=%0d d=%h want 1 3 12345678", bus.wr, bus.reg_sel, bus.reg_d);
        end
        n_checks++;
        if (bus.ld_pend !== 2'd0) begin n_fail++; $display("FAIL load_drained got pend=%0d want 0", bus.ld_pend); end
        @(negedge clk);
        n_checks++;
        if (bus.wr !== 1'b0) begin n_fail++; $display("FAIL load_after got wr=%0b want 0", bus.wr); end
    endtask

    task automatic test_starvation();
        logic [4:0] exp_sel   [7];
        logic       exp_stall [7];
        for (int i = 0; i < 7; i++) begin
            exp_sel[i]   = (i == 4) ? 5'd9 : 5'd1;
            exp_stall[i] = (i == 3);
        end
        bus.ld_valid = 1'b1;
        bus.ld_sel   = 5'd9;
        bus.ld_d     = 32'h00000099;
        @(negedge clk);
        bus.ld_valid = 1'b0;
        bus.alu_wr   = 1'b1;
        bus.alu_sel  = 5'd1;
        bus.alu_d    = 32'h00000011;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.wr !== 1'b1 || bus.reg_sel !== exp_sel[i] || bus.alu_stall !== exp_stall[i]) begin
                n_fail++;
                $display("FAIL starve[%0d] got wr=%0b sel=%0d stall=%0b want 1 %0d %0b", i, bus.wr, bus.reg_sel, bus.alu_stall, exp_sel[i], exp_stall[i]);
            end
            if (i == 4) begin
                n_checks++;
                if (bus.reg_d !== 32'h00000099 || bus.ld_pend !== 2'd0) begin
                    n_fail++;
                    $display("FAIL starve_load got d=%h pend=%0d want 00000099 0", bus.reg_d, bus.ld_pend);
                end
            end
        end
        bus.alu_wr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fifo_full();
        logic [4:0] got_sel [$];
        logic [31:0] got_d  [$];
        int  idx = 0;
        int  held = 0;
        int  ready_bad = 0;
        int  max_pend = 0;
        logic acc_pending = 1'b0;
        bus.alu_wr  = 1'b1;
        bus.alu_sel = 5'd2;
        bus.alu_d   = 32'h00000022;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (acc_pending) idx++;
            if (idx < 3) begin
                bus.ld_valid = 1'b1;
                bus.ld_sel   = 5'(10 + idx);
                bus.ld_d     = 32'hA0 + 32'(idx);
            end else begin
                bus.ld_valid = 1'b0;
            end
            acc_pending = bus.ld_valid && bus.ld_ready;
            if (bus.ld_valid && !bus.ld_ready && idx == 2) held++;
            @(negedge clk);
            if (int'(bus.ld_pend) > max_pend) max_pend = int'(bus.ld_pend);
            if (bus.ld_pend == 2'd2 && bus.ld_ready !== 1'b0) ready_bad++;
            if (bus.wr === 1'b1 && bus.reg_sel >= 5'd10) begin
                got_sel.push_back(bus.reg_sel);
                got_d.push_back(bus.reg_d);
            end
        end
        bus.alu_wr   = 1'b0;
        bus.ld_valid = 1'b0;
        n_checks++;
        if (max_pend !== 2) begin n_fail++; $display("FAIL full_pend got max=%0d want 2", max_pend); end
        n_checks++;
        if (ready_bad !== 0) begin n_fail++; $display("FAIL full_ready got %0d ready-while-full cycles want 0", ready_bad); end
        n_checks++;
        if (held == 0) begin n_fail++; $display("FAIL full_hold got %0d held cycles want >0", held); end
        n_checks++;
        if (got_sel.size() != 3) begin
            n_fail++;
            $display("FAIL full_count got %0d load writes want 3 (timeout)", got_sel.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (got_sel[i] !== 5'(10 + i) || got_d[i] !== 32'hA0 + 32'(i)) begin
                    n_fail++;
                    $display("FAIL full_order[%0d] got sel=%0d d=%h want %0d %h", i, got_sel[i], got_d[i], 10 + i, 32'hA0 + 32'(i));
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        int stale = 0;
        bus.alu_wr   = 1'b1;
        bus.alu_sel  = 5'd4;
        bus.alu_d    = 32'h00000044;
        bus.ld_valid = 1'b1;
        bus.ld_sel   = 5'd20;
        bus.ld_d     = 32'h00000020;
        @(negedge clk);
        bus.ld_sel = 5'd21;
        bus.ld_d   = 32'h00000021;
        @(negedge clk);
        bus.ld_valid = 1'b0;
        n_checks++;
        if (bus.ld_pend !== 2'd2 || bus.wr !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre got pend=%0d wr=%0b want 2 1", bus.ld_pend, bus.wr);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.wr !== 1'b0 || bus.ld_pend !== 2'd0 || bus.alu_stall !== 1'b0 || bus.ld_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_async got wr=%0b pend=%0d stall=%0b rdy=%0b want 0 0 0 0", bus.wr, bus.ld_pend, bus.alu_stall, bus.ld_ready);
        end
        bus.alu_wr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.wr !== 1'b0 || bus.ld_pend !== 2'd0) stale++;
        end
        n_checks++;
        if (stale != 0) begin n_fail++; $display("FAIL midrst_stale got %0d stale cycles want 0", stale); end
    endtask

    initial begin
        bus.alu_sel = '0;
        bus.alu_d   = '0;
        bus.ld_sel  = '0;
        bus.ld_d    = '0;
        idle_inputs();
        test_reset();
        test_alu_only();
        test_back_to_back();
        test_load_only();
        test_starvation();
        test_fifo_full();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/gppcu_thread_wrbk.md
# gppcu_thread_wrbk

Per-thread writeback arbiter for the GPPCU pipeline. It merges two result sources into the single write port of the thread register bank, which takes select, data and write-enable. The two sources are the single-cycle ALU result and out-of-order load returns from the memory side. Load returns are buffered in a small FIFO. A starvation counter guarantees that queued loads drain while the ALU is writing back continuously.

## Interface
- DW, 32, data width
- AW, 5, register select width (32 registers)
- LDQ_DEPTH, 2, load-return FIFO depth (power of two, ≥2)
- STARVE_MAX, 4, consecutive ALU wins over a pending load before the ALU is stalled for one cycle
- iACLK  in  1  clock, rising edge
- iARESETn  in  1  asynchronous active-low reset
- iALUWR  in  1  ALU result valid this cycle
- iALUSEL  in  AW  ALU destination register
- iALUD  in  DW  ALU result
- oALUSTALL  out  1  registered; while 1, the ALU input is ignored and upstream holds iALUWR/iALUSEL/iALUD unchanged
- iLDVALID  in  1  load return valid
- oLDREADY  out  1  registered; load return accepted on an edge where iLDVALID && oLDREADY
- iLDSEL  in  AW  load destination register
- iLDD  in  DW  load data
- oREGDSEL  out  AW  registered write select to the register bank
- oREGD  out  DW  registered write data
- oWR  out  1  registered write enable
- oLDPEND  out  log2(LDQ_DEPTH)+1  registered count of queued load returns

## Operation
- Reset values: oWR=0, oREGDSEL=0, oREGD=0, oALUSTALL=0, oLDREADY=0, oLDPEND=0. FIFO pointers and the starvation counter are cleared.
- oLDREADY rises on the first edge after reset release. From then on, oLDREADY_next = (count_next < LDQ_DEPTH).
- Grant, evaluated each cycle from the current state:
  - ALU wins if iALUWR && !oALUSTALL.
  - Otherwise, if the FIFO is non-empty, the head is popped.
  - Otherwise, no write.
- The winner's select and data are registered into oREGDSEL/oREGD, and oWR=1. On no write, oWR=0 and oREGDSEL/oREGD hold their previous values.
- FIFO push and pop in the same cycle are legal. count_next = count + push − pop.
- Push is blocked when full, even if a pop occurs that cycle, because oLDREADY reflects the registered state.
- There is no bypass: a load is never written in the cycle it is accepted.
- Starvation counter cnt, range 0..STARVE_MAX:
  - Increments when the ALU wins while the FIFO is non-empty.
  - Clears when a load is written or the FIFO is empty.
  - oALUSTALL_next = (cnt_next == STARVE_MAX).
- In a stall cycle the FIFO is non-empty by construction, the head is popped and cnt clears. The stall lasts exactly one cycle.
- No hazard checking between sources. Writes commit in grant order, and a later write to the same register overwrites an earlier one.
- Register 0 is not special-cased.

## Timing
- ALU path: result presented in cycle c is sampled at the end of c; oWR/oREGDSEL/oREGD are valid during c+1. Latency is 1.
- Load path: a return accepted at the end of cycle c is in the FIFO during c+1; the earliest write is valid during c+2. Minimum latency is 2.
- With iALUWR held at 1 and a load pending, the sequence is:
  - STARVE_MAX ALU writes.
  - oALUSTALL=1 for one cycle, during which one load is written.
  - ALU writes resume.
- In that sequence, worst-case wait of the FIFO head is STARVE_MAX+1 cycles after entering the queue.
- Asserting iARESETn mid-operation immediately forces all outputs to their reset values. Queued loads are discarded and the in-flight oWR is dropped.
- Throughput: one register write per cycle maximum.

## Test plan
- Reset release:
  - Stimulus: hold iARESETn=0 with iLDVALID=1 and iALUWR=1, then release.
  - Response: oWR=0 and oLDREADY=0 during reset; oLDREADY=1 one edge after release; no load is accepted before that.
- ALU only:
  - Stimulus: iALUWR=1, iALUSEL=7, iALUD=0xDEADBEEF for one cycle.
  - Response: next cycle oWR=1, oREGDSEL=7, oREGD=0xDEADBEEF; following cycle oWR=0.
- Load only:
  - Stimulus: accept iLDSEL=3, iLDD=0x12345678.
  - Response: oLDPEND=1 for one cycle; oWR=1, oREGDSEL=3, oREGD=0x12345678 two cycles after acceptance; then oLDPEND=0.
- Starvation:
  - Stimulus: queue one load to r9, then drive iALUWR=1 continuously to r1.
  - Response: exactly 4 ALU writes, then oALUSTALL=1 for one cycle with r9 written, then ALU writes resume and oALUSTALL=0.
- FIFO full:
  - Stimulus: with the ALU busy, push 3 loads back to back.
  - Response: the first 2 are accepted, oLDPEND=2, oLDREADY=0; the third is held until a pop; the loads are written in arrival order.
- Mid-operation reset:
  - Stimulus: assert iARESETn=0 with 2 queued loads and oWR=1.
  - Response: oWR, oLDPEND and oALUSTALL go to 0 immediately; after release no stale load write ever appears.
